// File: rtl/mem_loader_pkg.sv
// ============================================================================
// Module  : mem_loader_pkg
// Purpose : Shared types and constants for the UART memory loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_loader_pkg;

  // Loader frame states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_IDX = 3'd1,
    ST_HDR_CNT = 3'd2,
    ST_DATA    = 3'd3,
    ST_CSUM    = 3'd4,
    ST_ACK     = 3'd5
  } state_e;

  // Frame sync byte and response codes
  localparam logic [7:0] c_SYNC = 8'hA5;
  localparam logic [7:0] c_ACK  = 8'h06;
  localparam logic [7:0] c_NAK  = 8'h15;

  // Header count byte to dword count: 0 encodes 256, result limited to depth
  function automatic logic [8:0] clamp_count(input logic [7:0] raw, input int depth);
    logic [8:0] full;
    full = (raw == 8'd0) ? 9'd256 : {1'b0, raw};
    if (full > 9'(depth)) full = 9'(depth);
    return full;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_loader_assembler.sv
// ============================================================================
// Module  : dword_assembler
// Purpose : Big-endian byte-to-doubleword shift register with byte counter.
//           word_o already includes the byte being presented, so the caller
//           can register the complete word on the same edge as the last byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dword_assembler #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [7:0]   byte_i,
  output logic [N-1:0] word_o,
  output logic         complete_o
);

  localparam int BYTES = N / 8;
  localparam int BCW   = $clog2(BYTES);
  localparam logic [BCW-1:0] c_LAST = BCW'(BYTES - 1);

  // Only the first seven bytes need storage; the eighth is taken live.
  logic [N-9:0]   shift_q, shift_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;

  // Next-state for the shift register and byte position
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    if (clear_i) begin
      shift_d = '0;
      bcnt_d  = '0;
    end else if (valid_i) begin
      shift_d = {shift_q[N-17:0], byte_i};
      bcnt_d  = (bcnt_q == c_LAST) ? '0 : bcnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      bcnt_q  <= '0;
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign word_o     = {shift_q, byte_i};
  assign complete_o = valid_i && (bcnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module  : mem_loader
// Purpose : UART frame loader writing big-endian doublewords into the unified
//           memory, with XOR checksum, ACK/NAK reply and idle timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int N       = 64,
  parameter int L       = 128,
  parameter int TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_byte,
  output logic [1:0]   memwrite,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int AW   = $clog2(L);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PADW = N - AW - 3;
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [8:0]     cnt_q, cnt_d;
  logic [7:0]     csum_q, csum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [1:0]     memwrite_q, memwrite_d;
  logic [N-1:0]   dataadr_q, dataadr_d;
  logic [N-1:0]   writedata_q, writedata_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           good_q, good_d;

  logic           asm_clear;
  logic           asm_valid;
  logic [N-1:0]   asm_word;
  logic           asm_complete;
  logic           in_frame;

  dword_assembler #(
    .N (N)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (asm_clear),
    .valid_i    (asm_valid),
    .byte_i     (rx_byte),
    .word_o     (asm_word),
    .complete_o (asm_complete)
  );

  // The idle timer only runs while a frame is being received, not in ACK.
  assign in_frame = (state_q == ST_HDR_IDX) || (state_q == ST_HDR_CNT) ||
                    (state_q == ST_DATA)    || (state_q == ST_CSUM);

  // Frame FSM: next state, checksum, write strobe and reply handshake
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    memwrite_d  = 2'b00;
    dataadr_d   = dataadr_q;
    writedata_d = writedata_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    good_d      = good_q;
    asm_clear   = 1'b0;
    asm_valid   = 1'b0;

    if (in_frame) begin
      tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == c_SYNC)) begin
          state_d = ST_HDR_IDX;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_HDR_IDX: begin
        if (rx_valid) begin
          idx_d   = rx_byte[AW-1:0];
          csum_d  = rx_byte;
          state_d = ST_HDR_CNT;
        end
      end
      ST_HDR_CNT: begin
        if (rx_valid) begin
          cnt_d     = clamp_count(rx_byte, L);
          csum_d    = csum_q ^ rx_byte;
          asm_clear = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          asm_valid = 1'b1;
          csum_d    = csum_q ^ rx_byte;
          if (asm_complete) begin
            memwrite_d  = 2'b11;
            dataadr_d   = {{PADW{1'b0}}, idx_q, 3'b000};
            writedata_d = asm_word;
            idx_d       = idx_q + 1'b1;
            cnt_d       = cnt_q - 1'b1;
            if (cnt_q == 9'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          good_d     = (csum_q == rx_byte);
          tx_byte_d  = (csum_q == rx_byte) ? c_ACK : c_NAK;
          tx_valid_d = 1'b1;
          if (csum_q != rx_byte) err_d = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = good_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort a stalled frame; writes already issued are left in memory.
    if (in_frame && !rx_valid && (tmo_q == c_TMO_LAST)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      tmo_d   = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      memwrite_q  <= 2'b00;
      dataadr_q   <= '0;
      writedata_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      memwrite_q  <= memwrite_d;
      dataadr_q   <= dataadr_d;
      writedata_q <= writedata_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      good_q      <= good_d;
    end
  end

  assign memwrite  = memwrite_q;
  assign dataadr   = dataadr_q;
  assign writedata = writedata_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module  : tb_mem_loader
// Purpose : Scoreboard bench for mem_loader: stimulus pushes expected writes,
//           replies and done pulses; a negedge monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_loader;

  localparam int L   = 128;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic [1:0]  memwrite;
  logic [63:0] dataadr;
  logic [63:0] writedata;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          tag;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  bit         done_q[$];
  wr_t        mw;

  mem_loader #(.N(64), .L(L), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every DUT output event against the scoreboard queues
  always @(negedge clk) begin
    if (reset) begin
      if (memwrite != 2'b00) begin
        chk("memwrite_val", memwrite, 2'b11);
        if (wr_q.size() == 0) fail_now("stray_write");
        else begin
          mw = wr_q.pop_front();
          chk("wr_cycle", cyc, mw.tag);
          chk("wr_addr", dataadr, mw.addr);
          chk("wr_data", writedata, mw.data);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) fail_now("stray_tx");
        else chk("tx_byte", tx_byte, tx_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("stray_done");
        else void'(done_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle_gap(input int maxg);
    repeat ($urandom_range(0, maxg)) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    chk("busy_release", busy, 1'b0);
    tick();
    tick();
  endtask

  // Reference model: one frame at byte level; expected writes come from the
  // frame's byte list, dword index wrapping modulo L.
  task automatic run_frame(input logic [7:0] idx, input logic [7:0] cnt,
                           input logic [7:0] din[$], input bit bad_csum,
                           input int maxg, input bit stall);
    int         eff;
    int         base;
    logic [7:0] cs;
    logic [7:0] rsp;
    wr_t        w;
    eff  = (cnt == 8'd0) ? 256 : int'(cnt);
    if (eff > L) eff = L;
    base = int'(idx) % L;
    cs   = idx ^ cnt;
    for (int j = 0; j < eff * 8; j++) cs ^= din[j];
    if (bad_csum) cs ^= 8'h5A;
    rsp = bad_csum ? 8'h15 : 8'h06;
    tx_q.push_back(rsp);
    if (!bad_csum) done_q.push_back(1'b1);

    idle_gap(maxg); send(8'hA5);
    idle_gap(maxg); send(idx);
    idle_gap(maxg); send(cnt);
    chk("busy_in_frame", busy, 1'b1);
    chk("err_clear_on_hdr", err, 1'b0);
    for (int j = 0; j < eff * 8; j++) begin
      idle_gap(maxg);
      if (j % 8 == 7) begin
        w.tag  = cyc + 1;
        w.addr = 64'(((base + j / 8) % L) * 8);
        w.data = '0;
        for (int b = 0; b < 8; b++) w.data = (w.data << 8) | 64'(din[j - 7 + b]);
        wr_q.push_back(w);
      end
      send(din[j]);
    end
    idle_gap(maxg);
    if (stall) tx_ready = 1'b0;
    send(cs);
    if (stall) begin
      for (int i = 0; i < 20; i++) begin
        chk("stall_tx_valid", tx_valid, 1'b1);
        chk("stall_tx_byte", tx_byte, rsp);
        chk("stall_busy", busy, 1'b1);
        send((i == 2) ? 8'hA5 : 8'($urandom));
      end
      tx_ready = 1'b1;
    end
    wait_idle();
    chk("err_after_frame", err, bad_csum);
  endtask

  function automatic void rand_data(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] d[$];
    logic [7:0] c;
    int         e;

    // Reset state
    repeat (3) tick();
    chk("rst_memwrite", memwrite, 2'b00);
    chk("rst_dataadr", dataadr, 64'h0);
    chk("rst_writedata", writedata, 64'h0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b1;
    tick();

    // Single dword at index 5, good checksum
    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(8'h05, 8'h01, d, 1'b0, 0, 1'b0);

    // Index wrap at top of memory, back-to-back bytes
    rand_data(16, d);
    run_frame(8'h7F, 8'h02, d, 1'b0, 0, 1'b0);

    // Same single-dword frame with corrupted checksum
    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(8'h05, 8'h01, d, 1'b1, 1, 1'b0);

    // Timeout after header and three data bytes
    send(8'hA5); send(8'h20); send(8'h02);
    chk("tmo_err_cleared", err, 1'b0);
    send(8'h01); send(8'h02); send(8'h03);
    repeat (TMO + 5) tick();
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_err", err, 1'b1);
    chk("tmo_tx_valid", tx_valid, 1'b0);
    send(8'hA5);
    chk("tmo_sync_clears_err", err, 1'b0);
    chk("tmo_sync_busy", busy, 1'b1);
    repeat (TMO + 5) tick();
    chk("tmo2_err", err, 1'b1);

    // Reply stall with bytes arriving during ACK
    rand_data(8, d);
    run_frame(8'h03, 8'h01, d, 1'b0, 1, 1'b1);

    // Reset in the middle of a data dword, then a fresh frame
    send(8'hA5); send(8'h10); send(8'h03);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    reset = 1'b0;
    tick();
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_memwrite", memwrite, 2'b00);
    reset = 1'b1;
    tick();
    rand_data(24, d);
    run_frame(8'h10, 8'h03, d, 1'b0, 0, 1'b0);

    // Randomized frames, including a count of 0 clamped to the depth
    for (int r = 0; r < 8; r++) begin
      c = (r == 5) ? 8'h00 : 8'($urandom_range(1, 4));
      e = (c == 8'h00) ? L : int'(c);
      rand_data(e * 8, d);
      run_frame(8'($urandom), c, d, ($urandom_range(0, 3) == 0), 2, 1'b0);
    end

    tick();
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("tx_q_drained", 64'(tx_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
